// File: rtl/rsnn_pkg.sv
// ----------------------------------------------------------------------------
// rsnn_pkg
// Shared constants for the RSNN parameter path: default parameter width and
// count, load-FSM state encoding and the meaning of each parameter slot.
// No ports (package).
// ----------------------------------------------------------------------------
package rsnn_pkg;

    localparam int unsigned PARAM_W    = 8;
    localparam int unsigned NUM_PARAMS = 8;

    // Parameter-load FSM encoding
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } load_state_e;

    // Slot assignment inside one complete parameter set
    localparam int unsigned IDX_W0     = 0;
    localparam int unsigned IDX_W1     = 1;
    localparam int unsigned IDX_W2     = 2;
    localparam int unsigned IDX_W3     = 3;
    localparam int unsigned IDX_W4     = 4;
    localparam int unsigned IDX_W5     = 5;
    localparam int unsigned IDX_THRESH = 6;
    localparam int unsigned IDX_DECAY  = 7;

endpackage : rsnn_pkg

// File: rtl/param_register_bank.sv
// ----------------------------------------------------------------------------
// param_register_bank
// Collects one parameter byte per write strobe into a staging array and, when
// the last byte of a set lands, copies the whole set into a shadow bank in a
// single edge so the neuron core never observes a partially loaded set.
//
// Ports
//   clk               in   rising-edge clock
//   rst               in   synchronous active-high reset, highest priority
//   enable            in   global enable; low freezes every register
//   params_reg_enable in   write strobe, one byte per accepted cycle
//   data_in           in   byte written on an accepted strobe
//   clear             in   abort/restart the current load (shadow kept)
//   rd_addr           in   staging readback index
//   rd_data           out  registered staging[rd_addr], 0 when out of range
//   params_flat       out  committed shadow bank, entry i at [i*DATA_W +: DATA_W]
//   load_count        out  bytes accepted in the current load
//   params_ready      out  shadow bank holds a complete committed set
//   overflow          out  sticky: strobe seen while the staging set was full
// ----------------------------------------------------------------------------
module param_register_bank #(
    parameter int unsigned DATA_W     = rsnn_pkg::PARAM_W,
    parameter int unsigned NUM_PARAMS = rsnn_pkg::NUM_PARAMS,
    parameter int unsigned PTR_W      = $clog2(NUM_PARAMS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         params_reg_enable,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         clear,
    input  logic [PTR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [NUM_PARAMS*DATA_W-1:0] params_flat,
    output logic [PTR_W:0]               load_count,
    output logic                         params_ready,
    output logic                         overflow
);

    import rsnn_pkg::*;

    localparam int unsigned CNT_W = PTR_W + 1;

    load_state_e state_q, state_d;

    logic [NUM_PARAMS-1:0][DATA_W-1:0] staging_q, staging_d;
    logic [NUM_PARAMS-1:0][DATA_W-1:0] shadow_q,  shadow_d;
    logic [DATA_W-1:0]                 rd_data_q, rd_data_d;
    logic [PTR_W-1:0]                  wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0]                  load_count_q, load_count_d;
    logic                              params_ready_q, params_ready_d;
    logic                              overflow_q, overflow_d;

    logic acc_c;
    logic last_c;
    logic rd_in_range_c;

    // Clear wins over a same-cycle strobe; a full staging set ignores strobes
    assign acc_c         = enable && params_reg_enable && !clear && (state_q != ST_FULL);
    assign last_c        = (wr_ptr_q == PTR_W'(NUM_PARAMS - 1));
    assign rd_in_range_c = ({1'b0, rd_addr} < CNT_W'(NUM_PARAMS));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (enable) begin
            if (clear) begin
                state_d = ST_EMPTY;
            end else if (acc_c) begin
                state_d = last_c ? ST_FULL : ST_FILLING;
            end
        end
    end

    // Datapath next values: staging write, atomic commit, counters, readback
    always_comb begin
        staging_d      = staging_q;
        shadow_d       = shadow_q;
        rd_data_d      = rd_data_q;
        wr_ptr_d       = wr_ptr_q;
        load_count_d   = load_count_q;
        params_ready_d = params_ready_q;
        overflow_d     = overflow_q;

        if (enable) begin
            // Reads the pre-write staging value, so a same-cycle write returns old data
            rd_data_d = rd_in_range_c ? staging_q[rd_addr] : '0;

            if (clear) begin
                wr_ptr_d     = '0;
                load_count_d = '0;
                overflow_d   = 1'b0;
            end else if (acc_c) begin
                staging_d[wr_ptr_q] = data_in;
                if (last_c) begin
                    // Commit includes the byte landing on this edge
                    shadow_d       = staging_d;
                    params_ready_d = 1'b1;
                    wr_ptr_d       = '0;
                    load_count_d   = CNT_W'(NUM_PARAMS);
                end else begin
                    wr_ptr_d     = wr_ptr_q + PTR_W'(1);
                    load_count_d = (load_count_q == CNT_W'(NUM_PARAMS)) ?
                                   load_count_q : load_count_q + CNT_W'(1);
                end
            end else if (params_reg_enable && (state_q == ST_FULL)) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            staging_q      <= '0;
            shadow_q       <= '0;
            rd_data_q      <= '0;
            wr_ptr_q       <= '0;
            load_count_q   <= '0;
            params_ready_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            staging_q      <= staging_d;
            shadow_q       <= shadow_d;
            rd_data_q      <= rd_data_d;
            wr_ptr_q       <= wr_ptr_d;
            load_count_q   <= load_count_d;
            params_ready_q <= params_ready_d;
            overflow_q     <= overflow_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign params_flat  = shadow_q;
    assign load_count   = load_count_q;
    assign params_ready = params_ready_q;
    assign overflow     = overflow_q;

endmodule : param_register_bank

// File: tb/tb_param_register_bank.sv
// ----------------------------------------------------------------------------
// tb_param_register_bank
// Scoreboard bench: expected output values are queued alongside each stimulus
// step and compared against the DUT outputs after the clock edge.
// ----------------------------------------------------------------------------
module tb_param_register_bank;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_P  = 8;
    localparam int unsigned PTR_W  = 3;

    localparam int K_FLAT  = 0;
    localparam int K_READY = 1;
    localparam int K_CNT   = 2;
    localparam int K_OVF   = 3;
    localparam int K_RD    = 4;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic                    params_reg_enable;
    logic [DATA_W-1:0]       data_in;
    logic                    clear;
    logic [PTR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]       rd_data;
    logic [NUM_P*DATA_W-1:0] params_flat;
    logic [PTR_W:0]          load_count;
    logic                    params_ready;
    logic                    overflow;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    param_register_bank #(
        .DATA_W     (DATA_W),
        .NUM_PARAMS (NUM_P),
        .PTR_W      (PTR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .params_reg_enable (params_reg_enable),
        .data_in           (data_in),
        .clear             (clear),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .params_flat       (params_flat),
        .load_count        (load_count),
        .params_ready      (params_ready),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [63:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic push_all(input logic [63:0] flat, input logic rdy,
                            input logic [63:0] cnt, input logic ovf);
        push(K_FLAT, flat);
        push(K_READY, 64'(rdy));
        push(K_CNT, cnt);
        push(K_OVF, 64'(ovf));
    endtask

    task automatic drain(input string step);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_FLAT:  check({step, ".flat"},  params_flat, e.val);
                K_READY: check({step, ".ready"}, 64'(params_ready), e.val);
                K_CNT:   check({step, ".cnt"},   64'(load_count), e.val);
                K_OVF:   check({step, ".ovf"},   64'(overflow), e.val);
                default: check({step, ".rd"},    64'(rd_data), e.val);
            endcase
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        params_reg_enable = 1'b1;
        data_in           = b;
        tick();
        params_reg_enable = 1'b0;
    endtask

    task automatic load_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            strobe(8'(base + 8'(i)));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst               = 1'b0;
        enable            = 1'b1;
        params_reg_enable = 1'b0;
        data_in           = '0;
        clear             = 1'b0;
        rd_addr           = '0;
        #2;

        // Reset state
        push_all(64'h0, 1'b0, 64'd0, 1'b0);
        push(K_RD, 64'h0);
        do_reset();
        drain("reset");

        // Full load 0x11..0x88; ready only after the 8th byte
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                push(K_CNT, 64'(i + 1));
                push(K_READY, 64'd0);
                push(K_FLAT, 64'h0);
            end else begin
                push_all(64'h8877665544332211, 1'b1, 64'd8, 1'b0);
            end
            strobe(8'(8'h11 * (i + 1)));
            drain("load8");
        end
        rd_addr = 3'd3;
        push(K_RD, 64'h44);
        tick();
        drain("rd3");

        // Strobe held for 10 cycles: commit after 8, overflow from the 9th
        do_reset();
        params_reg_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 8'(8'h10 + 8'(i));
            if (i == 7) push_all(64'h1716151413121110, 1'b1, 64'd8, 1'b0);
            if (i >= 8) push_all(64'h1716151413121110, 1'b1, 64'd8, 1'b1);
            tick();
            drain("hold10");
        end
        params_reg_enable = 1'b0;

        // Clear leaves the committed set intact and drops overflow
        push_all(64'h1716151413121110, 1'b1, 64'd0, 1'b0);
        do_clear();
        drain("clr_full");

        // Commit 0xA0..0xA7, partial load of 3, then clear
        load_seq(8'hA0, 8);
        push_all(64'hA7A6A5A4A3A2A1A0, 1'b1, 64'd8, 1'b0);
        drain("loadA");
        do_clear();
        load_seq(8'hB0, 3);
        push(K_CNT, 64'd3);
        drain("partial3");
        push_all(64'hA7A6A5A4A3A2A1A0, 1'b1, 64'd0, 1'b0);
        do_clear();
        drain("clr_partial");

        // Freeze with enable low, then resume at the same index
        load_seq(8'hC0, 2);
        rd_addr = 3'd1;
        push(K_RD, 64'hC1);
        push(K_CNT, 64'd2);
        tick();
        drain("pre_freeze");
        enable  = 1'b0;
        rd_addr = 3'd2;
        for (int i = 0; i < 3; i++) begin
            params_reg_enable = 1'b1;
            data_in           = 8'hFF;
            clear             = (i == 1);
            push(K_CNT, 64'd2);
            push(K_RD, 64'hC1);
            tick();
            drain("freeze");
        end
        clear = 1'b0;
        enable = 1'b1;
        // Same-cycle write to the read index returns the previous contents
        push(K_RD, 64'hB2);
        push(K_CNT, 64'd3);
        strobe(8'hC2);
        drain("resume");
        push(K_RD, 64'hC2);
        tick();
        drain("resume_rd");

        // Clear and strobe together: byte dropped, next byte lands at index 0
        clear             = 1'b1;
        params_reg_enable = 1'b1;
        data_in           = 8'h5A;
        push_all(64'hA7A6A5A4A3A2A1A0, 1'b1, 64'd0, 1'b0);
        tick();
        clear             = 1'b0;
        params_reg_enable = 1'b0;
        drain("clr_strobe");
        push(K_CNT, 64'd1);
        strobe(8'h3C);
        drain("after_clr");
        rd_addr = 3'd0;
        push(K_RD, 64'h3C);
        tick();
        drain("rd0");

        // Reset mid-load wipes everything; a fresh load then commits
        do_clear();
        load_seq(8'hD0, 5);
        push(K_CNT, 64'd5);
        drain("mid5");
        rst = 1'b1;
        push_all(64'h0, 1'b0, 64'd0, 1'b0);
        push(K_RD, 64'h0);
        tick();
        rst = 1'b0;
        drain("rst_mid");
        load_seq(8'hE0, 8);
        push_all(64'hE7E6E5E4E3E2E1E0, 1'b1, 64'd8, 1'b0);
        drain("reload");
        rd_addr = 3'd7;
        push(K_RD, 64'hE7);
        tick();
        drain("rd7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_register_bank
